// File: rtl/any1_branch_resolve_queue.sv
// In-flight branch queue between fetch and execute: checks each resolved
// branch against its prediction, drives the predictor update and redirects fetch.
module any1_branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int AWID  = 32,
    parameter int ISZ   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     f_valid,
    input  logic [AWID-1:0]          f_ip,
    input  logic                     f_pred,
    input  logic [AWID-1:0]          f_tgt,
    output logic                     f_ready,
    input  logic                     x_valid,
    input  logic                     x_takb,
    input  logic [AWID-1:0]          x_tgt,
    input  logic                     flush,
    output logic                     xisBranch,
    output logic [AWID-1:0]          xip,
    output logic                     takb,
    output logic                     redirect_valid,
    output logic [AWID-1:0]          redirect_ip,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow,
    output logic [15:0]              mispredicts
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Head entry is read combinationally because the compare happens in the resolve cycle.
    logic [AWID-1:0] ip_mem   [DEPTH];
    logic [AWID-1:0] tgt_mem  [DEPTH];
    logic            pred_mem [DEPTH];

    logic [PW-1:0]   head_reg;
    logic [PW-1:0]   tail_reg;
    logic [AWID-1:0] head_ip;
    logic [AWID-1:0] head_tgt;
    logic            head_pred;
    logic            resolve;
    logic            mispredict_now;
    logic            push;
    logic [AWID-1:0] redirect_next;

    assign head_ip   = ip_mem[head_reg];
    assign head_tgt  = tgt_mem[head_reg];
    assign head_pred = pred_mem[head_reg];

    assign f_ready = (count != CW'(DEPTH));

    always_comb begin
        resolve        = x_valid && (count != '0) && !flush;
        mispredict_now = resolve && ((head_pred != x_takb) ||
                                     (x_takb && head_pred && (head_tgt != x_tgt)));
        push           = f_valid && f_ready && !flush && !mispredict_now;
        redirect_next  = x_takb ? x_tgt : head_ip + AWID'(ISZ);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ip_mem[tail_reg]   <= f_ip;
            tgt_mem[tail_reg]  <= f_tgt;
            pred_mem[tail_reg] <= f_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count          <= '0;
            underflow      <= 1'b0;
            mispredicts    <= '0;
            xisBranch      <= 1'b0;
            xip            <= '0;
            takb           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_ip    <= '0;
        end else begin
            xisBranch      <= 1'b0;
            redirect_valid <= 1'b0;

            if (flush) begin
                count    <= '0;
                tail_reg <= head_reg;
            end else if (mispredict_now) begin
                // Everything younger than the mispredicted branch is wrong-path.
                head_reg <= head_reg + 1'b1;
                tail_reg <= head_reg + 1'b1;
                count    <= '0;
            end else begin
                if (resolve) head_reg <= head_reg + 1'b1;
                if (push)    tail_reg <= tail_reg + 1'b1;
                count <= count + CW'(push) - CW'(resolve);
            end

            if (x_valid && count == '0) underflow <= 1'b1;

            if (resolve) begin
                xisBranch <= 1'b1;
                xip       <= head_ip;
                takb      <= x_takb;
            end

            if (mispredict_now) begin
                redirect_valid <= 1'b1;
                redirect_ip    <= redirect_next;
                if (mispredicts != 16'hFFFF) mispredicts <= mispredicts + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_any1_branch_resolve_queue.sv
// Directed bench for any1_branch_resolve_queue: expected updates go into a
// scoreboard queue, a negedge monitor pops and compares each xisBranch strobe.
module tb_any1_branch_resolve_queue;
    localparam int DEPTH = 8;
    localparam int AWID  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            f_valid;
    logic [AWID-1:0] f_ip;
    logic            f_pred;
    logic [AWID-1:0] f_tgt;
    logic            f_ready;
    logic            x_valid;
    logic            x_takb;
    logic [AWID-1:0] x_tgt;
    logic            flush;
    logic            xisBranch;
    logic [AWID-1:0] xip;
    logic            takb;
    logic            redirect_valid;
    logic [AWID-1:0] redirect_ip;
    logic [3:0]      count;
    logic            underflow;
    logic [15:0]     mispredicts;

    typedef struct {
        logic [AWID-1:0] ip;
        logic            tk;
        logic            redir;
        logic [AWID-1:0] rip;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    any1_branch_resolve_queue #(.DEPTH(DEPTH), .AWID(AWID), .ISZ(4)) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_ip(f_ip), .f_pred(f_pred), .f_tgt(f_tgt), .f_ready(f_ready),
        .x_valid(x_valid), .x_takb(x_takb), .x_tgt(x_tgt), .flush(flush),
        .xisBranch(xisBranch), .xip(xip), .takb(takb),
        .redirect_valid(redirect_valid), .redirect_ip(redirect_ip),
        .count(count), .underflow(underflow), .mispredicts(mispredicts)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (xisBranch === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_update: xip=0x%0h with no expected update", xip);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (xip !== e.ip || takb !== e.tk || redirect_valid !== e.redir ||
                    (e.redir && redirect_ip !== e.rip)) begin
                    failures++;
                    $display("FAIL update: got xip=0x%0h takb=%0b redir=%0b rip=0x%0h, expected xip=0x%0h takb=%0b redir=%0b rip=0x%0h",
                             xip, takb, redirect_valid, redirect_ip, e.ip, e.tk, e.redir, e.rip);
                end else begin
                    $display("upd  xip=0x%0h takb=%0b redir=%0b rip=0x%0h", xip, takb, redirect_valid, redirect_ip);
                end
            end
        end else if (redirect_valid === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL stray_redirect: redirect_valid=1 without update, rip=0x%0h", redirect_ip);
        end
    end

    task automatic idle_inputs();
        f_valid = 0; f_ip = '0; f_pred = 0; f_tgt = '0;
        x_valid = 0; x_takb = 0; x_tgt = '0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic [AWID-1:0] ip, input logic pred, input logic [AWID-1:0] tgt);
        f_valid = 1; f_ip = ip; f_pred = pred; f_tgt = tgt;
        tick();
    endtask

    // Resolve the oldest branch and record the hand-computed expected update.
    task automatic resolve(input logic tk, input logic [AWID-1:0] tgt,
                           input logic [AWID-1:0] eip, input logic eredir,
                           input logic [AWID-1:0] erip);
        exp_t e;
        e.ip = eip; e.tk = tk; e.redir = eredir; e.rip = erip;
        exp_q.push_back(e);
        x_valid = 1; x_takb = tk; x_tgt = tgt;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_f_ready", 64'(f_ready), 64'd1);
        chk("reset_xisBranch", 64'(xisBranch), 64'd0);
        chk("reset_redirect", 64'(redirect_valid), 64'd0);
        chk("reset_underflow", 64'(underflow), 64'd0);
        chk("reset_mispredicts", 64'(mispredicts), 64'd0);

        // Three correctly predicted branches.
        push(32'h100, 0, 32'h0);
        push(32'h200, 1, 32'h280);
        push(32'h300, 0, 32'h0);
        chk("count_after_3_push", 64'(count), 64'd3);
        resolve(0, 32'h0,   32'h100, 0, 32'h0);
        resolve(1, 32'h280, 32'h200, 0, 32'h0);
        resolve(0, 32'h0,   32'h300, 0, 32'h0);
        chk("count_after_drain", 64'(count), 64'd0);
        chk("no_mispredicts_yet", 64'(mispredicts), 64'd0);

        // Predicted not-taken, actually taken.
        push(32'h100, 0, 32'h0);
        resolve(1, 32'h400, 32'h100, 1, 32'h400);
        chk("mispredicts_1", 64'(mispredicts), 64'd1);

        // Predicted taken, actually not taken, with younger entries and a same-cycle push.
        push(32'h200, 1, 32'h500);
        push(32'h210, 0, 32'h0);
        push(32'h220, 0, 32'h0);
        chk("count_before_flush", 64'(count), 64'd3);
        f_valid = 1; f_ip = 32'h999; f_pred = 0; f_tgt = '0;
        resolve(0, 32'h0, 32'h200, 1, 32'h204);
        chk("count_after_mispredict", 64'(count), 64'd0);
        chk("mispredicts_2", 64'(mispredicts), 64'd2);
        push(32'h230, 0, 32'h0);
        chk("count_after_repush", 64'(count), 64'd1);
        resolve(0, 32'h0, 32'h230, 0, 32'h0);

        // Direction right, target wrong.
        push(32'h300, 1, 32'h500);
        resolve(1, 32'h600, 32'h300, 1, 32'h600);
        chk("mispredicts_3", 64'(mispredicts), 64'd3);

        // Fill, refuse ninth push, then pop and push+pop with pointer wrap.
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i) * 32'h10, 0, 32'h0);
        chk("count_full", 64'(count), 64'd8);
        chk("f_ready_full", 64'(f_ready), 64'd0);
        push(32'hBAD, 0, 32'h0);
        chk("count_after_refused_push", 64'(count), 64'd8);
        resolve(0, 32'h0, 32'h1000, 0, 32'h0);
        chk("count_after_pop_full", 64'(count), 64'd7);
        f_valid = 1; f_ip = 32'h1080; f_pred = 0; f_tgt = '0;
        resolve(0, 32'h0, 32'h1010, 0, 32'h0);
        chk("count_push_pop", 64'(count), 64'd7);
        for (int i = 2; i <= 8; i++) resolve(0, 32'h0, 32'h1000 + 32'(i) * 32'h10, 0, 32'h0);
        chk("count_after_wrap_drain", 64'(count), 64'd0);

        // Resolve with an empty queue.
        x_valid = 1; x_takb = 1; x_tgt = 32'h777;
        tick();
        tick();
        chk("underflow_set", 64'(underflow), 64'd1);

        // External flush beats a simultaneous mispredicting resolve.
        push(32'h500, 0, 32'h0);
        flush = 1; x_valid = 1; x_takb = 1; x_tgt = 32'h700;
        tick();
        tick();
        chk("count_after_flush", 64'(count), 64'd0);
        chk("mispredicts_after_flush", 64'(mispredicts), 64'd3);

        // Reset mid-operation.
        push(32'h600, 0, 32'h0);
        push(32'h610, 0, 32'h0);
        rst = 1;
        tick();
        rst = 0;
        chk("count_after_rst", 64'(count), 64'd0);
        chk("underflow_after_rst", 64'(underflow), 64'd0);
        chk("mispredicts_after_rst", 64'(mispredicts), 64'd0);

        tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
